// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared state and shift-unit function codes for the shift sequencer
package shift_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   localparam logic [1:0] SU_SHR_IN1 = 2'b00;
   localparam logic [1:0] SU_SHL_IN1 = 2'b01;
   localparam logic [1:0] SU_SHR_IN2 = 2'b10;
   localparam logic [1:0] SU_SHL_IN2 = 2'b11;

endpackage

// File: rtl/shift_u.sv
// rtl/shift_u.sv - combinational single-step logical shift unit
module shift_u
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             s_en,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [1:0]       alu_fun_su,
   output logic [WIDTH-1:0] shift_out
);

   always_comb begin
      shift_out = '0;
      if (s_en) begin
         case (alu_fun_su)
            SU_SHR_IN1: shift_out = in1 >> 1;
            SU_SHL_IN1: shift_out = in1 << 1;
            SU_SHR_IN2: shift_out = in2 >> 1;
            default:    shift_out = in2 << 1;
         endcase
      end
   end

endmodule

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - shift-by-N sequencer driving the single-step shift unit
module shift_seq_ctrl
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sel,
   input  logic             dir,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [CNT_W-1:0] amt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] opr, opr_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             dir_q, dir_nxt;
   logic             s_en;
   logic [1:0]       alu_fun_su;
   logic [WIDTH-1:0] shift_out;
   logic [CNT_W-1:0] amt_eff;

   // Clamping at WIDTH keeps the step count bounded and still yields an all-zero result.
   assign amt_eff    = (amt > WIDTH_CNT) ? WIDTH_CNT : amt;
   assign alu_fun_su = dir_q ? SU_SHL_IN1 : SU_SHR_IN1;
   assign busy       = (state != ST_IDLE);
   assign done       = (state == ST_FINISH);

   shift_u #(
      .WIDTH (WIDTH)
   ) u_shift (
      .s_en       (s_en),
      .in1        (opr),
      .in2        ('0),
      .alu_fun_su (alu_fun_su),
      .shift_out  (shift_out)
   );

   always_comb begin
      state_nxt = state;
      opr_nxt   = opr;
      cnt_nxt   = cnt;
      dir_nxt   = dir_q;
      s_en      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               opr_nxt   = sel ? b : a;
               dir_nxt   = dir;
               cnt_nxt   = amt_eff;
               state_nxt = (amt_eff == '0) ? ST_FINISH : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            s_en    = 1'b1;
            opr_nxt = shift_out;
            cnt_nxt = cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
               state_nxt = ST_FINISH;
            end
         end
         ST_FINISH: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         opr    <= '0;
         cnt    <= '0;
         dir_q  <= 1'b0;
         result <= '0;
      end else begin
         state <= state_nxt;
         opr   <= opr_nxt;
         cnt   <= cnt_nxt;
         dir_q <= dir_nxt;
         // Capture on the edge entering FINISH so RESULT moves together with DONE.
         if ((state != ST_FINISH) && (state_nxt == ST_FINISH)) begin
            result <= opr_nxt;
         end
      end
   end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - self-checking bench for shift_seq_ctrl
module tb_shift_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        sel;
   logic        dir;
   logic [15:0] a;
   logic [15:0] b;
   logic [4:0]  amt;
   logic        busy;
   logic        done;
   logic [15:0] result;

   int          n_pass  = 0;
   int          n_total = 0;
   logic [15:0] exp_prev = 16'h0;

   shift_seq_ctrl #(.WIDTH(16), .CNT_W(5)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .sel    (sel),
      .dir    (dir),
      .a      (a),
      .b      (b),
      .amt    (amt),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   function automatic int eff_of(input int n);
      return (n > 16) ? 16 : n;
   endfunction

   function automatic logic [15:0] model(input logic [15:0] op, input logic d, input int n);
      logic [31:0] x;
      x = {16'h0, op};
      if (d) x = x << eff_of(n);
      else   x = x >> eff_of(n);
      return x[15:0];
   endfunction

   // Issues one request at the current negedge and measures it until DONE.
   task automatic do_req(input logic [15:0] va, input logic [15:0] vb, input logic vsel,
                         input logic vdir, input logic [4:0] vamt, input logic collide,
                         output int lat, output int sen, output logic [15:0] res,
                         output logic hold_ok);
      a = va; b = vb; sel = vsel; dir = vdir; amt = vamt; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      lat = 0; sen = 0; hold_ok = 1'b1; res = 16'hxxxx;
      while (1) begin
         if (dut.s_en === 1'b1) sen++;
         if (done === 1'b1) begin
            res = result;
            break;
         end
         if (result !== exp_prev) hold_ok = 1'b0;
         if (lat >= 60) break;
         if (collide && lat == 1) begin
            start = 1'b1; sel = 1'b1; b = 16'hAAAA; a = 16'h5555; amt = 5'd1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
   endtask

   task automatic run_checked(input string name, input logic [15:0] va, input logic [15:0] vb,
                              input logic vsel, input logic vdir, input logic [4:0] vamt,
                              input logic collide, input logic [15:0] exp_res);
      int          lat, sen;
      logic [15:0] res;
      logic        hold_ok;
      int          e;
      e = eff_of(int'(vamt));
      do_req(va, vb, vsel, vdir, vamt, collide, lat, sen, res, hold_ok);
      n_total++;
      if (lat !== e) $display("FAIL %s latency: got %0d want %0d", name, lat, e);
      else n_pass++;
      n_total++;
      if (res !== exp_res) $display("FAIL %s result: got %h want %h", name, res, exp_res);
      else n_pass++;
      n_total++;
      if (sen !== e) $display("FAIL %s s_en cycles: got %0d want %0d", name, sen, e);
      else n_pass++;
      n_total++;
      if (hold_ok !== 1'b1) $display("FAIL %s result hold before done: got %b want 1", name, hold_ok);
      else n_pass++;
      exp_prev = exp_res;
      @(negedge clk);
      n_total++;
      if ({busy, done} !== 2'b00) $display("FAIL %s idle after done: got busy/done %b want 00", name, {busy, done});
      else n_pass++;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; sel = 1'b0; dir = 1'b0; a = '0; b = '0; amt = '0;
      repeat (2) @(negedge clk);
      n_total++;
      if ({busy, done, result, dut.s_en} !== 19'h0) $display("FAIL reset: got busy=%b done=%b result=%h s_en=%b want all 0", busy, done, result, dut.s_en);
      else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
      n_total++;
      if ({busy, done, result} !== 18'h0) $display("FAIL out_of_reset: got busy=%b done=%b result=%h want all 0", busy, done, result);
      else n_pass++;
      exp_prev = 16'h0;
   endtask

   task automatic test_directed;
      run_checked("left",     16'h00F0, 16'h0000, 1'b0, 1'b1, 5'd4,  1'b0, 16'h0F00);
      run_checked("right",    16'hFFFF, 16'h8001, 1'b1, 1'b0, 5'd1,  1'b0, 16'h4000);
      run_checked("zero_amt", 16'h1234, 16'h0000, 1'b0, 1'b0, 5'd0,  1'b0, 16'h1234);
      run_checked("oversize", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 5'd20, 1'b0, 16'h0000);
      run_checked("width",    16'h8000, 16'h0000, 1'b0, 1'b0, 5'd16, 1'b0, 16'h0000);
   endtask

   task automatic test_collision;
      int extra;
      run_checked("collision", 16'h0001, 16'h0000, 1'b0, 1'b1, 5'd6, 1'b1, 16'h0040);
      extra = 0;
      repeat (8) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) extra++;
      end
      n_total++;
      if (extra !== 0) $display("FAIL collision queued: got %0d busy/done cycles want 0", extra);
      else n_pass++;
   endtask

   task automatic test_reset_mid;
      int extra;
      a = 16'h0101; sel = 1'b0; dir = 1'b1; amt = 5'd6; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_total++;
      if ({busy, done, result} !== 18'h0) $display("FAIL reset_mid async clear: got busy=%b done=%b result=%h want all 0", busy, done, result);
      else n_pass++;
      exp_prev = 16'h0;
      @(negedge clk);
      rst_n = 1'b1;
      extra = 0;
      repeat (8) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) extra++;
      end
      n_total++;
      if (extra !== 0) $display("FAIL reset_mid stale activity: got %0d cycles want 0", extra);
      else n_pass++;
      run_checked("after_reset", 16'h0003, 16'h0000, 1'b0, 1'b1, 5'd2, 1'b0, 16'h000C);
   endtask

   task automatic test_random;
      logic [15:0] ra, rb;
      logic        rs, rd;
      logic [4:0]  ram;
      for (int i = 0; i < 24; i++) begin
         ra  = 16'($urandom);
         rb  = 16'($urandom);
         rs  = 1'($urandom);
         rd  = 1'($urandom);
         ram = 5'($urandom_range(0, 31));
         run_checked("random", ra, rb, rs, rd, ram, 1'b0, model(rs ? rb : ra, rd, int'(ram)));
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] ra;
      logic [4:0]  ram;
      for (int i = 0; i < 4; i++) begin
         ra  = 16'($urandom);
         ram = 5'($urandom_range(0, 3));
         run_checked("back_to_back", ra, 16'h0000, 1'b0, 1'(i), ram, 1'b0, model(ra, 1'(i), int'(ram)));
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_collision;
      test_reset_mid;
      test_random;
      test_back_to_back;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
